// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
// Holds the reset PC default and the NOP presented on an empty head.
package fetch_queue_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_2000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int          PC_STEP   = 4;

  // Occupancy counters need one bit more than the pointers to represent "full".
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of DEPTH {pc, instr} entries with synchronous reset and flush.
// Pointers wrap naturally; count distinguishes full from empty.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [XLEN-1:0]          push_pc,
  input  logic [XLEN-1:0]          push_instr,
  input  logic                     pop,
  input  logic                     flush,
  output logic [XLEN-1:0]          head_pc,
  output logic [XLEN-1:0]          head_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [2*XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              pop_ok;

  always_comb begin
    pop_ok     = pop & ~empty;
    full       = (count == DEPTH_C);
    empty      = (count == '0);
    head_pc    = mem[rptr][2*XLEN-1:XLEN];
    head_instr = mem[rptr][XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after count says it was written.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wptr] <= {push_pc, push_instr};
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential fetch with one outstanding icache request,
// credit-based issue into a DEPTH-entry queue, redirect flush and optional bypass.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(PC_RESET),
  parameter bit              BYPASS   = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  output logic [XLEN-1:0] icache_addr,
  output logic            icache_re,
  input  logic [XLEN-1:0] icache_dout,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc
);

  localparam int CW = count_width(DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight_v;

  logic [CW-1:0]   count;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_instr;
  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;

  logic            redirect;
  logic            arriving;
  logic            bypass_v;
  logic            pop;
  logic            issue;
  logic [CW:0]     credits_used;

  // NOTE: combinational logic uses blocking '=' so later lines see earlier results in the same pass.
  always_comb begin
    redirect = redirect_valid & ~stall & ~reset;
    // A response lands in every live cycle after an issue unless a redirect makes it stale.
    arriving = inflight_v & ~stall & ~redirect_valid & ~reset;
    bypass_v = BYPASS & fifo_empty & arriving;

    dec_valid = ~reset & (~fifo_empty | bypass_v);
    dec_pc    = fifo_empty ? inflight_pc : head_pc;
    dec_instr = fifo_empty ? (bypass_v ? icache_dout : INSTR_NOP) : head_instr;

    pop = dec_valid & dec_ready & ~stall;

    // Entries held plus the response still owed, less what leaves this cycle.
    credits_used = {1'b0, count} + (CW+1)'(inflight_v) - (CW+1)'(pop);
    issue        = ~stall & ~reset & (redirect | (credits_used < DEPTH_C));

    icache_re   = issue;
    icache_addr = redirect ? redirect_pc : fetch_pc;

    fifo_pop  = pop & ~fifo_empty;
    fifo_push = arriving & ~(bypass_v & pop) & (~fifo_full | fifo_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_v  <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (!stall) begin
      inflight_v <= issue;
      if (issue) begin
        fetch_pc    <= icache_addr + XLEN'(PC_STEP);
        inflight_pc <= icache_addr;
      end
    end
  end

  fetch_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_pc    (inflight_pc),
    .push_instr (icache_dout),
    .pop        (fifo_pop),
    .flush      (redirect),
    .head_pc    (head_pc),
    .head_instr (head_instr),
    .count      (count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  a_credit: assert property (@(posedge clk) disable iff (reset)
    (({1'b0, count} + (CW+1)'(inflight_v)) <= DEPTH_C));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    !(arriving && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: BYPASS=0 and BYPASS=1 instances share stimulus and are each
// compared every cycle against a queue-based reference model; directed phases then random traffic.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        dec_ready = 1'b0;
  logic [31:0] dout0 = '0, dout1 = '0;

  logic [31:0] addr0, addr1, instr0, instr1, pc0, pc1;
  logic        re0, re1, dv0, dv1;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_2000), .BYPASS(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .stall(stall),
    .icache_addr(addr0), .icache_re(re0), .icache_dout(dout0),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dv0), .dec_ready(dec_ready), .dec_instr(instr0), .dec_pc(pc0)
  );

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_2000), .BYPASS(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .stall(stall),
    .icache_addr(addr1), .icache_re(re1), .icache_dout(dout1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dv1), .dec_ready(dec_ready), .dec_instr(instr1), .dec_pc(pc1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: queue contents, next sequential PC, the one outstanding request.
  ent_t        mq0[$];
  ent_t        mq1[$];
  logic [31:0] m_fpc [2];
  logic [31:0] m_ipc [2];
  logic        m_inf [2];
  logic [31:0] pend  [2];

  logic [31:0] o_addr [2];
  logic [31:0] o_pc   [2];
  logic        o_re   [2];
  logic        o_v    [2];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic model_step(input int d);
    ent_t        q[$];
    ent_t        e;
    logic        red, arr, dv, pop, iss;
    logic [31:0] addr, din, g_instr;
    int          cnt;
    if (d == 0) begin q = mq0; din = dout0; g_instr = instr0; end
    else        begin q = mq1; din = dout1; g_instr = instr1; end
    red  = !stall && redirect_valid;
    addr = red ? redirect_pc : m_fpc[d];
    cnt  = q.size();
    arr  = m_inf[d] && !stall && !redirect_valid;
    dv   = (cnt > 0) || (d == 1 && arr);
    e    = (cnt > 0) ? q[0] : '{pc: m_ipc[d], instr: din};
    pop  = dv && dec_ready && !stall;
    iss  = !stall && (red || (cnt + int'(m_inf[d]) - int'(pop) < DEPTH));

    check($sformatf("u%0d.icache_addr", d), o_addr[d], addr);
    check($sformatf("u%0d.icache_re", d), 32'(o_re[d]), 32'(iss));
    check($sformatf("u%0d.dec_valid", d), 32'(o_v[d]), 32'(dv));
    if (dv) begin
      check($sformatf("u%0d.dec_pc", d), o_pc[d], e.pc);
      check($sformatf("u%0d.dec_instr", d), g_instr, e.instr);
    end

    if (!stall) begin
      if (red) q.delete();
      else begin
        if (pop && cnt > 0) void'(q.pop_front());
        if (arr && !(cnt == 0 && d == 1 && pop)) q.push_back('{pc: m_ipc[d], instr: din});
      end
      m_inf[d] = iss;
      if (iss) begin
        m_ipc[d] = addr;
        m_fpc[d] = addr + 32'd4;
      end
      pend[d] = addr;
    end
    if (d == 0) mq0 = q; else mq1 = q;
  endtask

  task automatic cycle(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    reset          = 1'b0;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_ready      = rdy;
    dout0          = instr_of(pend[0]);
    dout1          = instr_of(pend[1]);
    #1;
    o_addr[0] = addr0; o_re[0] = re0; o_v[0] = dv0; o_pc[0] = pc0;
    o_addr[1] = addr1; o_re[1] = re1; o_v[1] = dv1; o_pc[1] = pc1;
    model_step(0);
    model_step(1);
  endtask

  logic [31:0] held_addr;
  logic [31:0] tmp;

  initial begin
    // Reset must win over a pending redirect.
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h9999_0000; dec_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst.addr0", addr0, 32'h0000_2000);
    check("rst.addr1", addr1, 32'h0000_2000);
    check("rst.re0", 32'(re0), 32'd0);
    check("rst.re1", 32'(re1), 32'd0);
    check("rst.dv0", 32'(dv0), 32'd0);
    check("rst.dv1", 32'(dv1), 32'd0);
    for (int d = 0; d < 2; d++) begin
      m_fpc[d] = 32'h0000_2000; m_ipc[d] = 32'h0000_2000; m_inf[d] = 1'b0; pend[d] = 32'h0000_2000;
    end
    mq0.delete(); mq1.delete();

    // Sequential streaming.
    cycle(0, 0, 0, 1);
    check("first.addr", o_addr[0], 32'h0000_2000);
    check("first.re", 32'(o_re[0]), 32'd1);
    repeat (11) cycle(0, 0, 0, 1);

    // Decode blocked: queue fills and issue stops.
    repeat (8) cycle(0, 0, 0, 0);
    check("full.re0", 32'(o_re[0]), 32'd0);
    check("full.dv0", 32'(o_v[0]), 32'd1);

    // One pop, then redirect with 3 entries held and one request outstanding.
    cycle(0, 0, 0, 1);
    cycle(0, 1, 32'h0000_3000, 0);
    check("redir.addr", o_addr[0], 32'h0000_3000);
    cycle(0, 0, 0, 1);
    check("redir.t1.dv0", 32'(o_v[0]), 32'd0);
    cycle(0, 0, 0, 1);
    check("redir.t2.dv0", 32'(o_v[0]), 32'd1);
    check("redir.t2.pc0", o_pc[0], 32'h0000_3000);
    repeat (4) cycle(0, 0, 0, 1);

    // Five stalled cycles with a redirect pulse that must be ignored.
    cycle(1, 0, 0, 1);
    held_addr = o_addr[0];
    cycle(1, 0, 0, 1);
    check("stall.addr", o_addr[0], held_addr);
    cycle(1, 1, 32'h0000_5000, 1);
    check("stall.redir.addr", o_addr[0], held_addr);
    check("stall.redir.re", 32'(o_re[0]), 32'd0);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    check("stall.end.addr", o_addr[0], held_addr);
    repeat (6) cycle(0, 0, 0, 1);

    // Bypass: redirect into an empty queue, decode refuses the first presentation.
    cycle(0, 1, 32'h0000_4000, 1);
    cycle(0, 0, 0, 0);
    check("byp.t1.dv1", 32'(o_v[1]), 32'd1);
    check("byp.t1.pc1", o_pc[1], 32'h0000_4000);
    check("byp.t1.dv0", 32'(o_v[0]), 32'd0);
    cycle(0, 0, 0, 1);
    check("byp.t2.dv1", 32'(o_v[1]), 32'd1);
    check("byp.t2.pc1", o_pc[1], 32'h0000_4000);
    check("byp.t2.dv0", 32'(o_v[0]), 32'd1);
    check("byp.t2.pc0", o_pc[0], 32'h0000_4000);
    repeat (4) cycle(0, 0, 0, 1);

    // PC wrap-around.
    cycle(0, 1, 32'hFFFF_FFF8, 1);
    cycle(0, 0, 0, 1);
    check("wrap.addr.fffc", o_addr[0], 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1);
    check("wrap.addr.0", o_addr[0], 32'h0000_0000);
    repeat (8) cycle(0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tmp = $urandom();
      if ($urandom_range(0, 3) == 0) tmp = 32'hFFFF_FFF0;
      cycle($urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0,
            {tmp[31:2], 2'b00},
            $urandom_range(0, 9) < 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
